mc_datapath: RTL and testbench
==============================

# mc_datapath

Multi-cycle, parametrised successor to the single-cycle MIPS datapath. It integrates the datapath, a 32-entry register file, the ALU and its own FSM controller. It executes the same instruction subset over a single shared instruction/data memory port with a valid/ready handshake, so wait-state memories are supported. It sits between the top level and a unified memory or bus bridge.

## Interface
Parameters:
- XLEN, 32, datapath/register width; legal values 32 or 64. Instructions are always 32 bits, taken from mem_rdata[31:0].
- RESET_PC, 0, PC value loaded on reset.
- WORD_ADDR, 0: PC step is 4, branch offset is shifted left 2, jump target is {pc_plus[XLEN-1:28], instr[25:0], 2'b00}. 1: PC step is 1, offset is unshifted, jump target is {pc_plus[XLEN-1:26], instr[25:0]}.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  XLEN  transfer address
- mem_wdata  out  XLEN  store data
- mem_ready  in  1  transfer completes on the rising edge where mem_req & mem_ready
- mem_rdata  in  XLEN  read data; sampled on the completing edge
- pc  out  XLEN  current PC (architectural)
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- halt  out  1  sticky; set on an unsupported instruction

## Operation
- Internal registers: PC, IR, MDR, A, B, ALUOut, 32×XLEN register file. $0 always reads 0, and writes to it are dropped.
- Supported instructions:
  - R-type (op 000000), by funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), sll 000000 (shift by shamt instr[10:6]).
  - I/J-type, by opcode: lw 100011, sw 101011, beq 000100, bne 000101, blez 000110 (signed A ≤ 0), addi 001000, lui 001111, j 000010.
- Any other opcode or funct goes to HALT.
- Immediates: signimm = sign-extend of instr[15:0] to XLEN. The lui result is sign-extend of {instr[15:0], 16'b0} to XLEN. All arithmetic is modulo 2^XLEN, with no overflow traps.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On completion: IR ← rdata[31:0], PC ← PC+step. Next state DECODE.
  - DECODE: A ← rf[rs], B ← rf[rt], ALUOut ← PC + offset (branch target). Dispatch by opcode.
  - MEMADR: ALUOut ← A + signimm. Goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD: read request at ALUOut. On completion: MDR ← rdata. Next state MEMWB.
  - MEMWB: rf[rt] ← MDR, retire. Next state FETCH.
  - MEMWR: write request with addr=ALUOut, wdata=B. On completion: retire, next state FETCH.
  - EXEC: ALUOut ← A op B (R-type), A + signimm (addi), or the lui value. Next state ALUWB.
  - ALUWB: rf[rd] (R-type) or rf[rt] (addi/lui) ← ALUOut, retire. Next state FETCH.
  - BRANCH: if the condition is true, PC ← ALUOut. Retire, next state FETCH.
  - JUMP: PC ← jump target. Retire, next state FETCH.
  - HALT: terminal. halt=1, mem_req=0. Only reset exits it.

## Timing
- Reset asserted (reset=0), applied asynchronously:
  - PC=RESET_PC, state=FETCH, all registers and the register file cleared.
  - Outputs: mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, retire=0, halt=0.
  - mem_req is forced to 0 while reset is low.
- First fetch request appears in the first cycle after reset deasserts.
- Handshake rules:
  - While mem_req=1, mem_addr, mem_we and mem_wdata are stable until the completing edge.
  - mem_ready may already be high in the request's first cycle (zero wait).
  - mem_req is 0 in every non-memory state.
  - The FSM does not leave a memory state without completion.
- Zero-wait latencies: lw 5, sw 4, R-type/addi/lui 4, beq/bne/blez 3, j 3 cycles. Each wait cycle adds 1.
- retire asserts for exactly one cycle per instruction. It is never asserted in HALT.
- Reset asserted mid-transfer aborts the transfer immediately: mem_req drops in the same cycle, and no register-file write occurs.

## Test plan
- Reset/fetch: hold reset low for 3 cycles, mem_ready tied to 1, RESET_PC=0. Required: mem_req=0 during reset; first request has mem_addr=0, we=0; pc reads 4 at DECODE.
- ALU chain: program 0x20010005 (addi $1,$0,5), 0x00211020 (add $2,$1,$1), 0xAC020010 (sw $2,0x10($0)). Required: write request with addr 0x10, wdata 10; retire at cycles 4, 8, 12.
- Wait states: lw $3,0x10($0) (0x8C030010) with mem_ready delayed 3 cycles on both fetch and data, rdata=0xDEADBEEF. Required: retire after 11 cycles; a following sw $3 writes 0xDEADBEEF.
- Branch: 0x1000FFFF (beq $0,$0,-1) at 0x20. Required: the next fetch is again at 0x20. bne $0,$0 falls through to 0x24. blez with A=−1 is taken.
- lui/sll: 0x3C041234 then 0x00042900. Required: $5=0x23400000. With XLEN=64, lui 0x8000 gives 0xFFFFFFFF80000000.
- Halt and abort: fetched word 0xFC000000 gives halt=1 and mem_req=0 indefinitely. Separately, reset asserted during lw wait drops mem_req in the same cycle and returns pc to RESET_PC.

Source files
------------

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core: PC/IR/MDR/A/B/ALUOut, 32-entry regfile, ALU, FSM control.
// Zero-wait latency: lw 5, sw 4, R-type/addi/lui 4, beq/bne/blez 3, j 3 cycles; +1 per wait cycle.
// Memory backpressure: a memory state holds its request stable until mem_ready completes it.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_req/mem_we/mem_addr/mem_wdata -> shared instruction/data port, mem_ready/mem_rdata <-
//   pc (architectural PC), retire (1-cycle pulse per instruction), halt (sticky, unsupported op)
module mc_datapath #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter bit              WORD_ADDR = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;

  localparam logic [XLEN-1:0] STEP = WORD_ADDR ? XLEN'(1) : XLEN'(4);

  state_t state, state_nx;

  logic [31:0]     ir;
  logic [XLEN-1:0] mdr, a, b, alu_out;
  logic [XLEN-1:0] rf [32];

  // Instruction fields
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];

  logic [XLEN-1:0] signimm, lui_val, br_off, jtarget, alu_res;
  logic            funct_ok, br_taken;

  assign signimm = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign lui_val = {{(XLEN-16){ir[15]}}, ir[15:0]} << 16;
  assign br_off  = WORD_ADDR ? signimm : {signimm[XLEN-3:0], 2'b00};
  // pc already holds the incremented value by the time JUMP runs
  assign jtarget = WORD_ADDR ? {pc[XLEN-1:26], ir[25:0]}
                             : {pc[XLEN-1:28], ir[25:0], 2'b00};

  assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                    (funct == F_OR)  || (funct == F_SLT) || (funct == F_SLL);

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BEQ:  br_taken = (a == b);
      OP_BNE:  br_taken = (a != b);
      OP_BLEZ: br_taken = a[XLEN-1] || (a == '0);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   alu_res = a + b;
        F_SUB:   alu_res = a - b;
        F_AND:   alu_res = a & b;
        F_OR:    alu_res = a | b;
        F_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        F_SLL:   alu_res = b << shamt;
        default: alu_res = '0;
      endcase
    end else if (op == OP_ADDI) begin
      alu_res = a + signimm;
    end else if (op == OP_LUI) begin
      alu_res = lui_val;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state logic; mem_ready only matters in the three request states
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                 state_nx = funct_ok ? S_EXEC : S_HALT;
          OP_LW, OP_SW:             state_nx = S_MEMADR;
          OP_BEQ, OP_BNE, OP_BLEZ:  state_nx = S_BRANCH;
          OP_ADDI, OP_LUI:          state_nx = S_EXEC;
          OP_J:                     state_nx = S_JUMP;
          default:                  state_nx = S_HALT;
        endcase
      end
      S_MEMADR: state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
      S_EXEC:   state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_JUMP:   state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_HALT;
    endcase
  end

  // Outputs and register-file write controls
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  always_comb begin
    // reset gating makes an in-flight transfer vanish the moment reset falls
    mem_req   = reset && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
    mem_we    = (state == S_MEMWR);
    mem_addr  = ((state == S_MEMRD) || (state == S_MEMWR)) ? alu_out : pc;
    mem_wdata = b;
    retire    = reset && ((state == S_MEMWB) || (state == S_ALUWB) ||
                          (state == S_BRANCH) || (state == S_JUMP) ||
                          ((state == S_MEMWR) && mem_ready));
    halt      = (state == S_HALT);
    rf_we     = (state == S_MEMWB) || (state == S_ALUWB);
    rf_waddr  = ((state == S_ALUWB) && (op == OP_RTYPE)) ? rd : rt;
    rf_wdata  = (state == S_MEMWB) ? mdr : alu_out;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata[31:0];
          pc <= pc + STEP;
        end
        S_DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc + br_off;
        end
        S_MEMADR: alu_out <= a + signimm;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_EXEC:   alu_out <= alu_res;
        S_BRANCH: if (br_taken) pc <= alu_out;
        S_JUMP:   pc <= jtarget;
        default: ;
      endcase
    end
  end

  // Register file; entry 0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  logic        clk, reset;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic        m64_req, m64_we, m64_ready, m64_retire, m64_halt;
  logic [63:0] m64_addr, m64_wdata, m64_rdata, m64_pc;

  mc_datapath #(.XLEN(32), .RESET_PC(32'h0), .WORD_ADDR(1'b0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc(pc), .retire(retire), .halt(halt));

  mc_datapath #(.XLEN(64), .RESET_PC(64'h0), .WORD_ADDR(1'b0)) dut64 (
    .clk(clk), .reset(reset), .mem_req(m64_req), .mem_we(m64_we),
    .mem_addr(m64_addr), .mem_wdata(m64_wdata), .mem_ready(m64_ready),
    .mem_rdata(m64_rdata), .pc(m64_pc), .retire(m64_retire), .halt(m64_halt));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } txn_t;

  int checks = 0, errors = 0;

  logic [31:0] mem  [256];   // memory seen by the DUT
  logic [31:0] mmem [256];   // reference model's own memory image
  logic [31:0] mem64 [32];
  logic [63:0] st64_addr, st64_data;

  // Reference ISA model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  bit          active, m_halted;
  int          cyc, next_start, exp_retire, halt_cyc, delay, wcnt;
  txn_t        exp_q [$];
  int          retire_log [$];
  logic [31:0] addr_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rlog(input int i);
    return (i < retire_log.size()) ? retire_log[i] : -1;
  endfunction

  function automatic logic [31:0] alog(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF;
  endfunction

  // Executes one whole instruction architecturally and predicts its bus
  // transactions and retire cycle from the instruction's cycle budget.
  task automatic model_step();
    logic [31:0] w, rsv, rtv, imm, npc, addr, res;
    logic [4:0]  wreg;
    int          lat, ntr;
    bit          wr;
    txn_t        t;
    w = mmem[m_pc[9:2]];
    t.addr = m_pc; t.we = 1'b0; t.wdata = 32'h0;
    exp_q.push_back(t);
    npc = m_pc + 32'd4;
    rsv = m_rf[w[25:21]];
    rtv = m_rf[w[20:16]];
    imm = {{16{w[15]}}, w[15:0]};
    lat = 0; ntr = 1; wr = 1'b0; wreg = 5'd0; res = 32'h0; addr = 32'h0;
    case (w[31:26])
      6'h00: begin
        lat = 4; wr = 1'b1; wreg = w[15:11];
        case (w[5:0])
          6'h20:   res = rsv + rtv;
          6'h22:   res = rsv - rtv;
          6'h24:   res = rsv & rtv;
          6'h25:   res = rsv | rtv;
          6'h2A:   res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
          6'h00:   res = rtv << w[10:6];
          default: lat = 0;
        endcase
      end
      6'h23: begin
        lat = 5; ntr = 2; addr = rsv + imm;
        t.addr = addr; t.we = 1'b0; t.wdata = 32'h0; exp_q.push_back(t);
        res = mmem[addr[9:2]]; wr = 1'b1; wreg = w[20:16];
      end
      6'h2B: begin
        lat = 4; ntr = 2; addr = rsv + imm;
        t.addr = addr; t.we = 1'b1; t.wdata = rtv; exp_q.push_back(t);
        mmem[addr[9:2]] = rtv;
      end
      6'h04: begin lat = 3; if (rsv == rtv) npc = npc + (imm << 2); end
      6'h05: begin lat = 3; if (rsv != rtv) npc = npc + (imm << 2); end
      6'h06: begin lat = 3; if ($signed(rsv) <= 0) npc = npc + (imm << 2); end
      6'h08: begin lat = 4; res = rsv + imm; wr = 1'b1; wreg = w[20:16]; end
      6'h0F: begin lat = 4; res = {w[15:0], 16'h0}; wr = 1'b1; wreg = w[20:16]; end
      6'h02: begin lat = 3; npc = {npc[31:28], w[25:0], 2'b00}; end
      default: lat = 0;
    endcase
    if (lat == 0) begin
      m_halted   = 1'b1;
      halt_cyc   = cyc + 2 + delay;
      exp_retire = -1;
    end else begin
      if (wr && wreg != 5'd0) m_rf[wreg] = res;
      m_pc       = npc;
      exp_retire = cyc + lat - 1 + delay * ntr;
      next_start = exp_retire + 1;
    end
  endtask

  // Memory responder plus per-cycle comparison against the model
  initial begin
    txn_t t;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!active) begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end else begin
        cyc++;
        if (!m_halted && cyc == next_start) begin
          check("pc_at_insn_start", {32'h0, pc}, {32'h0, m_pc});
          model_step();
        end
        if (mem_req) begin
          if (wcnt >= delay) begin
            mem_ready = 1'b1;
            wcnt      = 0;
            mem_rdata = mem[mem_addr[9:2]];
            addr_log.push_back(mem_addr);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_request: got addr %h we %b, expected no request", mem_addr, mem_we);
            end else begin
              t = exp_q.pop_front();
              check("txn_addr", {32'h0, mem_addr}, {32'h0, t.addr});
              check("txn_we", {63'h0, mem_we}, {63'h0, t.we});
              if (t.we) check("txn_wdata", {32'h0, mem_wdata}, {32'h0, t.wdata});
            end
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          end else begin
            mem_ready = 1'b0;
            wcnt++;
          end
        end else begin
          mem_ready = 1'b0;
          wcnt      = 0;
        end
        #1;
        check("retire", {63'h0, retire}, {63'h0, (cyc == exp_retire)});
        if (retire) retire_log.push_back(cyc);
        check("halt", {63'h0, halt}, {63'h0, (m_halted && cyc >= halt_cyc)});
        if (m_halted && cyc >= halt_cyc) check("req_after_halt", {63'h0, mem_req}, 64'h0);
      end
    end
  end

  // Zero-wait memory for the 64-bit instance; captures its last store
  initial begin
    m64_ready = 1'b1;
    m64_rdata = 64'h0;
    st64_addr = 64'h0;
    st64_data = 64'h0;
    forever begin
      @(negedge clk);
      m64_rdata = {32'h0, mem64[m64_addr[6:2]]};
      if (m64_req && m64_we) begin
        st64_addr = m64_addr;
        st64_data = m64_wdata;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; mmem[i] = 32'h0; end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    mem[idx] = w; mmem[idx] = w;
  endtask

  task automatic start_run(input int d);
    active = 1'b0;
    reset  = 1'b0;
    delay  = d;
    repeat (3) begin
      @(negedge clk);
      check("req_in_reset", {63'h0, mem_req}, 64'h0);
    end
    check("rst_pc", {32'h0, pc}, 64'h0);
    check("rst_addr", {32'h0, mem_addr}, 64'h0);
    check("rst_wdata", {32'h0, mem_wdata}, 64'h0);
    check("rst_we_retire_halt", {61'h0, mem_we, retire, halt}, 64'h0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_pc = 32'h0; m_halted = 1'b0;
    exp_q.delete(); retire_log.delete(); addr_log.delete();
    cyc = 0; next_start = 1; exp_retire = 0; halt_cyc = 0; wcnt = 0;
    @(posedge clk); #1;
    reset  = 1'b1;
    active = 1'b1;
  endtask

  task automatic stop_after(input int n);
    repeat (n) @(posedge clk);
    #1;
    active = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 32; i++) mem64[i] = 32'h0;
    mem64[0] = 32'h3C018000;   // lui $1,0x8000
    mem64[1] = 32'hAC010040;   // sw  $1,0x40($0)
    mem64[2] = 32'hFC000000;   // unsupported -> halt

    // ALU chain, zero wait
    clear_mem();
    put(0, 32'h20010005);
    put(1, 32'h00211020);
    put(2, 32'hAC020010);
    put(3, 32'hFC000000);
    start_run(0);
    @(posedge clk); #2;
    check("pc_at_decode", {32'h0, pc}, 64'h4);
    stop_after(19);
    check("alu_retire0", rlog(0), 4);
    check("alu_retire1", rlog(1), 8);
    check("alu_retire2", rlog(2), 12);
    check("alu_store", {32'h0, mem[4]}, 64'd10);
    check("alu_halt", {63'h0, halt}, 64'h1);
    check("x64_lui_store_data", st64_data, 64'hFFFF_FFFF_8000_0000);
    check("x64_lui_store_addr", st64_addr, 64'h40);
    check("x64_halt", {63'h0, m64_halt}, 64'h1);

    // Three wait states on every transfer
    clear_mem();
    put(0, 32'h8C030010);
    put(1, 32'hAC030014);
    put(2, 32'hFC000000);
    put(4, 32'hDEADBEEF);
    start_run(3);
    stop_after(32);
    check("wait_lw_retire", rlog(0), 11);
    check("wait_sw_retire", rlog(1), 21);
    check("wait_sw_data", {32'h0, mem[5]}, 64'hDEADBEEF);

    // j to 0x20, then beq $0,$0,-1 spins on itself
    clear_mem();
    put(0, 32'h08000008);
    put(8, 32'h1000FFFF);
    start_run(0);
    stop_after(10);
    check("jump_fetch", {32'h0, alog(1)}, 64'h20);
    check("beq_refetch", {32'h0, alog(2)}, 64'h20);

    // bne fall-through, blez taken, lui/sll, sub/slt/and/or
    clear_mem();
    put(0,  32'h2001FFFF);   // addi $1,$0,-1
    put(1,  32'h14000005);   // bne  $0,$0,+5
    put(2,  32'h18200002);   // blez $1,+2 -> 0x14
    put(3,  32'hFC000000);
    put(4,  32'hFC000000);
    put(5,  32'h3C041234);   // lui  $4,0x1234
    put(6,  32'h00042900);   // sll  $5,$4,4
    put(7,  32'hAC050040);   // sw   $5,0x40
    put(8,  32'h00013022);   // sub  $6,$0,$1
    put(9,  32'h0026382A);   // slt  $7,$1,$6
    put(10, 32'h00244024);   // and  $8,$1,$4
    put(11, 32'h00C44825);   // or   $9,$6,$4
    put(12, 32'hAC090044);   // sw   $9,0x44
    put(13, 32'hAC080048);   // sw   $8,0x48
    put(14, 32'hAC07004C);   // sw   $7,0x4C
    put(15, 32'hFC000000);
    start_run(0);
    stop_after(60);
    check("bne_fallthrough", {32'h0, alog(2)}, 64'h8);
    check("blez_taken", {32'h0, alog(3)}, 64'h14);
    check("lui_sll", {32'h0, mem[16]}, 64'h23400000);
    check("or_result", {32'h0, mem[17]}, 64'h12340001);
    check("and_result", {32'h0, mem[18]}, 64'h12340000);
    check("slt_result", {32'h0, mem[19]}, 64'h1);
    check("final_halt", {63'h0, halt}, 64'h1);

    // Reset during the data wait of a lw
    clear_mem();
    put(0, 32'h8C030010);
    put(4, 32'hDEADBEEF);
    start_run(3);
    repeat (6) @(posedge clk);
    #2;
    active = 1'b0;
    check("abort_req_before", {63'h0, mem_req}, 64'h1);
    check("abort_addr_before", {32'h0, mem_addr}, 64'h10);
    reset = 1'b0;
    #1;
    check("abort_req_dropped", {63'h0, mem_req}, 64'h0);
    check("abort_pc", {32'h0, pc}, 64'h0);
    check("abort_addr", {32'h0, mem_addr}, 64'h0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
